event_logger: RTL and testbench

- Timestamped event log for the lock, directly downstream of the time-of-day counter.
- Captures each lock event code together with the current hours/minutes/seconds into a circular buffer of records.
- Records are read back oldest-first by the display/readout logic.
- When the buffer is full, a new event overwrites the oldest record, so the log always holds the most recent DEPTH events.

---
 rtl/event_logger_if.sv | 34 +++
 rtl/event_logger.sv | 104 ++++++++++
 tb/tb_event_logger.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/event_logger_if.sv
// Event logger bus: event capture inputs, readout handshake and log status.
//   master : the side that raises events and requests reads (lock / readout logic)
//   slave  : the logger itself
// Signals:
//   clear, ev_valid, ev_code[2:0], seconds[5:0], minutes[5:0], hours[4:0], rd_req : master -> slave
//   rd_valid, rd_data[19:0], rd_err, count[ADDR_W:0], empty, full, overflow         : slave -> master
interface event_logger_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              clear;
  logic              ev_valid;
  logic [2:0]        ev_code;
  logic [5:0]        seconds;
  logic [5:0]        minutes;
  logic [4:0]        hours;
  logic              rd_req;
  logic              rd_valid;
  logic [19:0]       rd_data;
  logic              rd_err;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    output clear, ev_valid, ev_code, seconds, minutes, hours, rd_req,
    input  rd_valid, rd_data, rd_err, count, empty, full, overflow
  );

  modport slave (
    input  clear, ev_valid, ev_code, seconds, minutes, hours, rd_req,
    output rd_valid, rd_data, rd_err, count, empty, full, overflow
  );
endinterface

// File: rtl/event_logger.sv
// Timestamped lock event log: circular buffer of DEPTH records, read back oldest-first.
// A write into a full log overwrites the oldest record and sets the sticky overflow flag.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : event_logger_if.slave (event capture, read handshake, status)
// Record layout: {code[19:17], hours[16:12], minutes[11:6], seconds[5:0]}
module event_logger #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  event_logger_if.slave  bus
);

  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne    = (ADDR_W + 1)'(1);

  logic [19:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_rd_valid;
  logic              r_rd_err;
  logic [19:0]       r_rd_data;

  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;
  logic              w_rd_err;
  logic              w_overwrite;
  logic [19:0]       w_record;

  assign w_full   = (r_count == FullCount);
  assign w_empty  = (r_count == '0);
  assign w_record = {bus.ev_code, bus.hours, bus.minutes, bus.seconds};

  // clear wins over everything else in the same cycle
  assign w_wr        = bus.ev_valid && (bus.ev_code != 3'd0) && !bus.clear;
  assign w_rd        = bus.rd_req && !w_empty && !bus.clear;
  assign w_rd_err    = bus.rd_req && w_empty && !bus.clear;
  // A simultaneous read frees a slot, so only a lone write into a full log overwrites
  assign w_overwrite = w_wr && !w_rd && w_full;

  // Buffer storage carries no reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_record;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else if (bus.clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      r_rd_err   <= w_rd_err;
      if (w_rd) begin
        // Reads the pre-edge contents, so a same-edge write to this slot is not seen
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_rd || w_overwrite) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      if (w_overwrite) begin
        r_overflow <= 1'b1;
      end
      if (w_wr && !w_rd && !w_full) begin
        r_count <= r_count + CntOne;
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - CntOne;
      end
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_err   = r_rd_err;
  assign bus.rd_data  = r_rd_data;
  assign bus.count    = r_count;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_event_logger.sv
module tb_event_logger;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  event_logger_if #(.ADDR_W(4)) bus ();

  event_logger #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] rec(input logic [2:0] c, input logic [4:0] h,
                                      input logic [5:0] m, input logic [5:0] s);
    return {c, h, m, s};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear    = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_code  = 3'd0;
    bus.seconds  = 6'd0;
    bus.minutes  = 6'd0;
    bus.hours    = 5'd0;
    bus.rd_req   = 1'b0;
  endtask

  task automatic write_ev(input logic [2:0] c, input logic [4:0] h,
                          input logic [5:0] m, input logic [5:0] s);
    bus.ev_valid = 1'b1;
    bus.ev_code  = c;
    bus.hours    = h;
    bus.minutes  = m;
    bus.seconds  = s;
    tick();
    bus.ev_valid = 1'b0;
    bus.ev_code  = 3'd0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    checks++; if (bus.count !== 5'd0) begin errors++;
      $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL reset_flags: full %b ovf %b want 0 0", bus.full, bus.overflow); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.rd_data !== 20'h0) begin
      errors++;
      $display("FAIL reset_rd: valid %b err %b data %h want 0 0 00000",
               bus.rd_valid, bus.rd_err, bus.rd_data); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    write_ev(3'd1, 5'd12, 6'd34, 6'd56);
    checks++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin errors++;
      $display("FAIL basic_count_after_write: count %0d empty %b want 1 0", bus.count, bus.empty); end
    repeat (3) tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++;
      $display("FAIL basic_no_early_valid: got %b want 0", bus.rd_valid); end
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 20'h2C8B8) begin errors++;
      $display("FAIL basic_read: valid %b data %h want 1 2c8b8", bus.rd_valid, bus.rd_data); end
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errors++;
      $display("FAIL basic_count_after_read: count %0d empty %b want 0 1", bus.count, bus.empty); end
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 20'h2C8B8) begin errors++;
      $display("FAIL basic_pulse_hold: valid %b data %h want 0 2c8b8", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_empty_read();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin errors++;
      $display("FAIL empty_read_err: err %b valid %b want 1 0", bus.rd_err, bus.rd_valid); end
    checks++; if (bus.count !== 5'd0 || bus.rd_data !== 20'h2C8B8) begin errors++;
      $display("FAIL empty_read_state: count %0d data %h want 0 2c8b8", bus.count, bus.rd_data); end
    tick();
    checks++; if (bus.rd_err !== 1'b0) begin errors++;
      $display("FAIL empty_read_pulse: err %b want 0", bus.rd_err); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 18; i++) write_ev(3'd2, 5'd1, 6'd2, 6'(i));
    checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_status: count %0d full %b ovf %b want 16 1 1",
               bus.count, bus.full, bus.overflow); end
    for (int i = 0; i < 16; i++) begin
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== rec(3'd2, 5'd1, 6'd2, 6'(i + 2))) begin
        errors++;
        $display("FAIL ovf_read_%0d: valid %b data %h want 1 %h", i, bus.rd_valid, bus.rd_data,
                 rec(3'd2, 5'd1, 6'd2, 6'(i + 2)));
      end
    end
    checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL ovf_drained: empty %b ovf %b count %0d want 1 1 0",
               bus.empty, bus.overflow, bus.count); end
  endtask

  task automatic test_full_rw();
    do_clear();
    for (int i = 0; i < 16; i++) write_ev(3'd4, 5'd23, 6'd59, 6'(20 + i));
    checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL fullrw_pre: full %b ovf %b want 1 0", bus.full, bus.overflow); end
    bus.rd_req = 1'b1;
    write_ev(3'd3, 5'd5, 6'd6, 6'd50);
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rec(3'd4, 5'd23, 6'd59, 6'd20)) begin
      errors++;
      $display("FAIL fullrw_oldest: valid %b data %h want 1 %h", bus.rd_valid, bus.rd_data,
               rec(3'd4, 5'd23, 6'd59, 6'd20)); end
    checks++; if (bus.count !== 5'd16 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL fullrw_status: count %0d ovf %b want 16 0", bus.count, bus.overflow); end
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_data !== rec(3'd4, 5'd23, 6'd59, 6'd21) || bus.count !== 5'd15) begin
      errors++;
      $display("FAIL fullrw_second: data %h count %0d want %h 15", bus.rd_data, bus.count,
               rec(3'd4, 5'd23, 6'd59, 6'd21)); end
  endtask

  task automatic test_code0_clear();
    write_ev(3'd0, 5'd1, 6'd1, 6'd1);
    checks++; if (bus.count !== 5'd15) begin errors++;
      $display("FAIL code0_ignored: count %0d want 15", bus.count); end
    write_ev(3'd7, 5'd2, 6'd3, 6'd4);
    write_ev(3'd5, 5'd2, 6'd3, 6'd5);
    checks++; if (bus.count !== 5'd16 || bus.overflow !== 1'b1) begin errors++;
      $display("FAIL code0_refill: count %0d ovf %b want 16 1", bus.count, bus.overflow); end
    bus.clear  = 1'b1;
    bus.rd_req = 1'b1;
    write_ev(3'd1, 5'd3, 6'd3, 6'd3);
    bus.clear  = 1'b0;
    bus.rd_req = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.overflow !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL clear_status: count %0d ovf %b empty %b want 0 0 1",
               bus.count, bus.overflow, bus.empty); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0) begin errors++;
      $display("FAIL clear_rd: valid %b err %b want 0 0", bus.rd_valid, bus.rd_err); end
    // Read + write on an empty log: error pulse, write still lands
    bus.rd_req = 1'b1;
    write_ev(3'd6, 5'd4, 6'd4, 6'd4);
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0 || bus.count !== 5'd1) begin
      errors++;
      $display("FAIL empty_rw: err %b valid %b count %0d want 1 0 1",
               bus.rd_err, bus.rd_valid, bus.count); end
  endtask

  task automatic test_async_reset();
    logic seen;
    // One record held; reset while the read request is presented
    bus.rd_req = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0 ||
                  bus.rd_data !== 20'h0) begin errors++;
      $display("FAIL areset_immediate: count %0d empty %b valid %b data %h want 0 1 0 00000",
               bus.count, bus.empty, bus.rd_valid, bus.rd_data); end
    bus.rd_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (bus.rd_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL areset_no_valid: rd_valid rose %b want 0", seen); end
    // Reset right after the read edge clears the valid pulse without a clock edge
    write_ev(3'd2, 5'd9, 6'd9, 6'd9);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++;
      $display("FAIL areset_pre_valid: got %b want 1", bus.rd_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 20'h0 || bus.full !== 1'b0 ||
                  bus.overflow !== 1'b0 || bus.rd_err !== 1'b0) begin errors++;
      $display("FAIL areset_mid: valid %b data %h full %b ovf %b err %b want 0 00000 0 0 0",
               bus.rd_valid, bus.rd_data, bus.full, bus.overflow, bus.rd_err); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_empty_read();
    test_overflow();
    test_full_rw();
    test_code0_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
